// File: rtl/interp_acc_4tap.sv
// Sums four signed tap products, adds the rounding offset, normalises and clips to an
// unsigned pixel. Tags every output with its column index and an end-of-row flag.
module interp_acc_4tap #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 8,
    parameter int SHIFT     = 6,
    parameter int N_SAMPLES = 32,
    parameter int CNT_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sync_clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  p0,
    input  logic signed [IN_W-1:0]  p1,
    input  logic signed [IN_W-1:0]  p2,
    input  logic signed [IN_W-1:0]  p3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_pix,
    output logic [CNT_W-1:0]        out_idx,
    output logic                    out_last
);

    localparam int A_W   = IN_W + 1;
    localparam int SUM_W = IN_W + 3;
    localparam logic signed [SUM_W-1:0] RND      = SUM_W'(1 << (SHIFT - 1));
    localparam logic signed [SUM_W-1:0] PIX_MAX  = SUM_W'((1 << OUT_W) - 1);
    localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(N_SAMPLES - 1);

    function automatic logic signed [SUM_W-1:0] add_round(
        input logic signed [A_W-1:0] a,
        input logic signed [A_W-1:0] b
    );
        return {{2{a[A_W-1]}}, a} + {{2{b[A_W-1]}}, b} + RND;
    endfunction

    // Arithmetic shift floors toward minus infinity; negatives clip to 0.
    function automatic logic [OUT_W-1:0] shift_clip(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] q;
        q = s >>> SHIFT;
        if (q < 0)
            return '0;
        else if (q > PIX_MAX)
            return '1;
        else
            return q[OUT_W-1:0];
    endfunction

    logic                    en;
    logic                    vld_p1;
    logic                    vld_p2;
    logic                    vld_p3;
    logic signed [A_W-1:0]   a_p1;
    logic signed [A_W-1:0]   b_p1;
    logic signed [SUM_W-1:0] s_p2;
    logic [CNT_W-1:0]        cnt;

    // Global stall: the whole pipe freezes while the output is held.
    assign en        = ~vld_p3 | out_ready;
    assign in_ready  = en & ~sync_clr;
    assign out_valid = vld_p3;

    // cnt counts valid S3 loads, so the index follows output order regardless of stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            vld_p3   <= 1'b0;
            cnt      <= '0;
            out_pix  <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
        end else if (sync_clr) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            vld_p3   <= 1'b0;
            cnt      <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
        end else if (en) begin
            vld_p1  <= in_valid & in_ready;
            vld_p2  <= vld_p1;
            vld_p3  <= vld_p2;
            out_pix <= shift_clip(s_p2);
            if (vld_p2) begin
                out_idx  <= cnt;
                out_last <= (cnt == LAST_IDX);
                cnt      <= (cnt == LAST_IDX) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // S1: pairwise sums; S2: total plus rounding offset
    always_ff @(posedge clk) begin
        if (en) begin
            a_p1 <= {p0[IN_W-1], p0} + {p1[IN_W-1], p1};
            b_p1 <= {p2[IN_W-1], p2} + {p3[IN_W-1], p3};
            s_p2 <= add_round(a_p1, b_p1);
        end
    end

endmodule

// File: tb/tb_interp_acc_4tap.sv
// Directed bench for interp_acc_4tap: latency, rounding/clipping, backpressure,
// index wrap, synchronous flush and asynchronous reset mid-stream.
module tb_interp_acc_4tap;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sync_clr;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] p0, p1, p2, p3;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_pix;
    logic [4:0]         out_idx;
    logic               out_last;

    int nchecks = 0;
    int nerr    = 0;

    logic signed [15:0] vp0 [80];
    logic signed [15:0] vp1 [80];
    logic signed [15:0] vp2 [80];
    logic signed [15:0] vp3 [80];
    logic [7:0]         ex_pix [80];

    logic [7:0] got_pix [$];
    logic [4:0] got_idx [$];
    logic       got_last [$];

    always #5 clk = ~clk;

    interp_acc_4tap dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_clr  (sync_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p0        (p0),
        .p1        (p1),
        .p2        (p2),
        .p3        (p3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // Inputs change at posedge+1, so the negedge sees what the next edge will transfer.
    always @(negedge clk) begin
        if (rst_n && !sync_clr && out_valid && out_ready) begin
            got_pix.push_back(out_pix);
            got_idx.push_back(out_idx);
            got_last.push_back(out_last);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input int a, input int b, input int c, input int d,
                           input int pix);
        vp0[i] = 16'(a);
        vp1[i] = 16'(b);
        vp2[i] = 16'(c);
        vp3[i] = 16'(d);
        ex_pix[i] = 8'(pix);
    endtask

    task automatic drive_vec(input int i);
        p0 = vp0[i];
        p1 = vp1[i];
        p2 = vp2[i];
        p3 = vp3[i];
    endtask

    task automatic clear_q();
        got_pix.delete();
        got_idx.delete();
        got_last.delete();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        sync_clr  = 1'b0;
        out_ready = 1'b1;
        p0 = '0; p1 = '0; p2 = '0; p3 = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_q();
    endtask

    // Streams vectors 0..n-1; out_ready is low for stream cycles st_from..st_to.
    task automatic run_stream(input int n, input int st_from, input int st_to, input string tag);
        int         j = 0;
        int         c = 0;
        logic       acc;
        logic       was_stall = 1'b0;
        logic [7:0] held_pix = '0;
        logic [4:0] held_idx = '0;
        clear_q();
        while ((j < n || got_pix.size() < n) && c < 400) begin
            in_valid = (j < n);
            drive_vec((j < n) ? j : 0);
            out_ready = !(c >= st_from && c <= st_to);
            @(negedge clk);
            acc = in_valid & in_ready;
            if (out_valid && !out_ready) begin
                check({tag, "_stall_in_ready"}, 32'(in_ready), 0);
                if (was_stall) begin
                    check({tag, "_hold_pix"}, 32'(out_pix), 32'(held_pix));
                    check({tag, "_hold_idx"}, 32'(out_idx), 32'(held_idx));
                end
                held_pix  = out_pix;
                held_idx  = out_idx;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            tick();
            if (acc) j++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_budget"}, (c >= 400) ? 1 : 0, 0);
        for (int k = 0; k < 5; k++) tick();
        check({tag, "_count"}, 32'(got_pix.size()), 32'(n));
        for (int k = 0; k < n && k < got_pix.size(); k++) begin
            check($sformatf("%s_pix%0d", tag, k), 32'(got_pix[k]), 32'(ex_pix[k]));
            check($sformatf("%s_idx%0d", tag, k), 32'(got_idx[k]), k % 32);
            check($sformatf("%s_last%0d", tag, k), 32'(got_last[k]), (k % 32 == 31) ? 1 : 0);
        end
    endtask

    initial begin
        // Reset state and basic latency
        do_reset();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_pix", 32'(out_pix), 0);
        check("rst_out_idx", 32'(out_idx), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        p0 = -16'sd300; p1 = 16'sd5800; p2 = 16'sd3600; p3 = -16'sd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_v_e1", 32'(out_valid), 0);
        tick();
        check("lat_v_e2", 32'(out_valid), 0);
        tick();
        check("lat_v_e3", 32'(out_valid), 1);
        check("basic_pix", 32'(out_pix), 141);
        check("basic_idx", 32'(out_idx), 0);
        check("basic_last", 32'(out_last), 0);
        tick();
        check("lat_v_e4", 32'(out_valid), 0);

        // Rounding and clipping boundaries
        do_reset();
        set_vec(0, 16000, 16000, 16000, 16000, 255);
        set_vec(1, -1000, -1000, -1000, -1000, 0);
        set_vec(2, 95, 0, 0, 0, 1);
        set_vec(3, -33, 0, 0, 0, 0);
        set_vec(4, 32767, 32767, 32767, 32767, 255);
        set_vec(5, 31, 0, 0, 0, 0);
        set_vec(6, 32, 0, 0, 0, 1);
        set_vec(7, 4080, 4080, 4080, 4080, 255);
        set_vec(8, 4064, 4064, 4064, 4064, 254);
        set_vec(9, -32768, -32768, -32768, -32768, 0);
        set_vec(10, -300, 5800, 3600, -100, 141);
        set_vec(11, 100, -50, 1000, -10, 16);
        set_vec(12, -64, 0, 0, 128, 1);
        run_stream(13, -1, -1, "clip");

        // Backpressure
        do_reset();
        for (int i = 0; i < 8; i++) set_vec(i, 16 * (i + 1), 16 * (i + 1), 16 * (i + 1), 16 * (i + 1), i + 1);
        run_stream(8, 4, 9, "bp");

        // Index wrap over 70 outputs
        do_reset();
        for (int i = 0; i < 70; i++) set_vec(i, 16 * i, 16 * i, 16 * i, 16 * i, i);
        run_stream(70, -1, -1, "wrap");

        // Synchronous flush with three sets in flight plus a fourth presented
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            p0 = 16'(16 * i); p1 = 16'(16 * i); p2 = 16'(16 * i); p3 = 16'(16 * i);
            in_valid = 1'b1;
            tick();
        end
        p0 = 16'sd144; p1 = 16'sd144; p2 = 16'sd144; p3 = 16'sd144;
        sync_clr = 1'b1;
        @(negedge clk);
        check("flush_pre_valid", 32'(out_valid), 1);
        check("flush_in_ready", 32'(in_ready), 0);
        tick();
        sync_clr = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 0);
        check("flush_out_idx", 32'(out_idx), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("flush_drop%0d", k), 32'(out_valid), 0);
        end
        check("flush_no_xfer", 32'(got_pix.size()), 0);
        set_vec(0, 112, 112, 112, 112, 7);
        run_stream(1, -1, -1, "postflush");

        // Asynchronous reset while an output is held
        do_reset();
        out_ready = 1'b0;
        p0 = 16'sd80; p1 = 16'sd80; p2 = 16'sd80; p3 = 16'sd80;
        in_valid = 1'b1;
        tick();
        p0 = 16'sd96; p1 = 16'sd96; p2 = 16'sd96; p3 = 16'sd96;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_valid_before", 32'(out_valid), 1);
        check("mid_pix_before", 32'(out_pix), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_pix", 32'(out_pix), 0);
        check("mid_rst_idx", 32'(out_idx), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        set_vec(0, 160, 160, 160, 160, 10);
        set_vec(1, 176, 176, 176, 176, 11);
        set_vec(2, 192, 192, 192, 192, 12);
        run_stream(3, -1, -1, "postrst");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
